// File: rtl/vend_pkg.sv
// Shared types and constants for the Coke vending controller: state encoding,
// coin codes and coin values in cents.
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        REFUND  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NICKEL  = 2'b00;
    localparam logic [1:0] COIN_DIME    = 2'b01;
    localparam logic [1:0] COIN_QUARTER = 2'b10;
    localparam logic [1:0] COIN_INVALID = 2'b11;

    localparam int         COIN_VAL_W  = 5;
    localparam logic [4:0] VAL_NICKEL  = 5'd5;
    localparam logic [4:0] VAL_DIME    = 5'd10;
    localparam logic [4:0] VAL_QUARTER = 5'd25;

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: maps the acceptor's coin code to a value in
// cents plus an invalid flag.
module vend_coin_decode
    import vend_pkg::*;
(
    input  logic [1:0]            coin_type,
    output logic [COIN_VAL_W-1:0] value,
    output logic                  invalid
);

    always_comb begin
        value   = '0;
        invalid = 1'b0;
        case (coin_type)
            COIN_NICKEL:  value = VAL_NICKEL;
            COIN_DIME:    value = VAL_DIME;
            COIN_QUARTER: value = VAL_QUARTER;
            default:      invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/coke_vend_ctrl.sv
// Coin-accumulating vend sequencer: credits coins, pulses dispense at PRICE and
// pays back leftover or cancelled credit one nickel per cycle.
// Optional build macro SALES_COUNT_EN adds a 16-bit wrapping sales_count output.
//
// state   | meaning
// IDLE    | no credit, waiting for the first coin
// COLLECT | credit below PRICE, accepting coins or cancel
// VEND    | dispense solenoid driven for DISPENSE_CYCLES cycles
// REFUND  | one nickel pulse per cycle until credit is exhausted
module coke_vend_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE           = 75,
    parameter int CREDIT_W        = 8,
    parameter int MAX_CREDIT      = 200,
    parameter int DISPENSE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    input  logic                cancel,
    output logic                dispense,
    output logic                nickel_out,
    output logic                coin_reject,
    output logic                busy,
`ifdef SALES_COUNT_EN
    output logic [15:0]         sales_count,
`endif
    output logic [CREDIT_W-1:0] credit
);

    localparam int SUM_W = CREDIT_W + 1;
    localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

    state_t                 state;
    logic [CNT_W-1:0]       disp_cnt;
    logic [COIN_VAL_W-1:0]  coin_val;
    logic                   coin_bad;
    logic [SUM_W-1:0]       sum;
    logic                   accept;

    vend_coin_decode u_coin_decode (
        .coin_type (coin_type),
        .value     (coin_val),
        .invalid   (coin_bad)
    );

    // One spare bit on the sum so the ceiling check sees true overflow.
    assign sum    = {1'b0, credit} + SUM_W'(coin_val);
    assign accept = coin_valid && !coin_bad && (sum <= SUM_W'(MAX_CREDIT))
                    && (state == IDLE || state == COLLECT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            credit      <= '0;
            dispense    <= 1'b0;
            nickel_out  <= 1'b0;
            coin_reject <= 1'b0;
            busy        <= 1'b0;
            disp_cnt    <= '0;
`ifdef SALES_COUNT_EN
            sales_count <= '0;
`endif
        end else begin
            coin_reject <= coin_valid && !accept;
            nickel_out  <= 1'b0;
            case (state)
                IDLE, COLLECT: begin
                    if (accept) begin
                        if (cancel) begin
                            state      <= REFUND;
                            credit     <= CREDIT_W'(sum - SUM_W'(VAL_NICKEL));
                            nickel_out <= 1'b1;
                            busy       <= 1'b1;
                        end else if (sum >= SUM_W'(PRICE)) begin
                            state    <= VEND;
                            credit   <= CREDIT_W'(sum - SUM_W'(PRICE));
                            dispense <= 1'b1;
                            disp_cnt <= CNT_W'(DISPENSE_CYCLES - 1);
                            busy     <= 1'b1;
`ifdef SALES_COUNT_EN
                            sales_count <= sales_count + 16'd1;
`endif
                        end else begin
                            state  <= COLLECT;
                            credit <= CREDIT_W'(sum);
                        end
                    end else if (cancel && state == COLLECT) begin
                        state      <= REFUND;
                        credit     <= credit - CREDIT_W'(VAL_NICKEL);
                        nickel_out <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                VEND: begin
                    if (disp_cnt == '0) begin
                        dispense <= 1'b0;
                        if (credit != '0) begin
                            state      <= REFUND;
                            credit     <= credit - CREDIT_W'(VAL_NICKEL);
                            nickel_out <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        disp_cnt <= disp_cnt - 1'b1;
                    end
                end
                REFUND: begin
                    // The pulse that brought credit to zero was the last one.
                    if (credit == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        credit     <= credit - CREDIT_W'(VAL_NICKEL);
                        nickel_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    credit   <= '0;
                    dispense <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coke_vend_ctrl.sv
// Self-checking bench for coke_vend_ctrl: directed scenarios plus random coin
// traffic checked every cycle against a credit/pulse-budget model.
module tb_coke_vend_ctrl;

    localparam int TB_PRICE = 75;
    localparam int TB_MAX   = 200;
    localparam int TB_DC    = 4;
    localparam logic [1:0] NK = 2'b00, DM = 2'b01, QT = 2'b10, BAD = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid, cancel;
    logic [1:0] coin_type;
    logic       dispense, nickel_out, coin_reject, busy;
    logic [7:0] credit;
`ifdef SALES_COUNT_EN
    logic [15:0] sales_count, sales_count2;
`endif

    logic       cv2, cn2;
    logic [1:0] ct2;
    logic       d2, n2, r2, b2;
    logic [7:0] c2;

    always #5 clk = ~clk;

    coke_vend_ctrl #(.PRICE(TB_PRICE), .CREDIT_W(8), .MAX_CREDIT(TB_MAX), .DISPENSE_CYCLES(TB_DC)) u_dut (
        .clk(clk), .reset(reset), .coin_valid(coin_valid), .coin_type(coin_type), .cancel(cancel),
        .dispense(dispense), .nickel_out(nickel_out), .coin_reject(coin_reject), .busy(busy),
`ifdef SALES_COUNT_EN
        .sales_count(sales_count),
`endif
        .credit(credit)
    );

    coke_vend_ctrl #(.PRICE(200), .CREDIT_W(8), .MAX_CREDIT(200), .DISPENSE_CYCLES(TB_DC)) u_hi (
        .clk(clk), .reset(reset), .coin_valid(cv2), .coin_type(ct2), .cancel(cn2),
        .dispense(d2), .nickel_out(n2), .coin_reject(r2), .busy(b2),
`ifdef SALES_COUNT_EN
        .sales_count(sales_count2),
`endif
        .credit(c2)
    );

    int tests = 0;
    int fails = 0;

    // Model: credit plus budgets of dispense cycles and nickel pulses still owed.
    int m_credit, vend_left, nick_left, m_sales;
    bit in_session, e_disp, e_nick, e_rej, e_busy;
    int disp_seen, nick_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int coin_val(input logic [1:0] t);
        case (t)
            NK: return 5;
            DM: return 10;
            QT: return 25;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_credit = 0; vend_left = 0; nick_left = 0; m_sales = 0;
        in_session = 0; e_disp = 0; e_nick = 0; e_rej = 0; e_busy = 0;
    endtask

    task automatic model_step(input bit v, input logic [1:0] t, input bit c);
        bit was_busy;
        bit ok;
        int val;
        was_busy = e_busy;
        val = coin_val(t);
        ok = v && (t != BAD) && !was_busy && (m_credit + val <= TB_MAX);
        e_rej = v && !ok;
        if (!was_busy) begin
            if (ok) begin
                m_credit += val;
                if (c) nick_left = m_credit / 5;
                else if (m_credit >= TB_PRICE) begin
                    m_credit -= TB_PRICE;
                    vend_left = TB_DC;
                    m_sales = (m_sales + 1) % 65536;
                end else in_session = 1;
            end else if (c && in_session) begin
                nick_left = m_credit / 5;
            end
            if (vend_left > 0 || nick_left > 0) in_session = 0;
        end else if (vend_left > 0) begin
            vend_left--;
            if (vend_left == 0 && m_credit > 0) nick_left = m_credit / 5;
        end
        e_nick = 0;
        if (nick_left > 0) begin
            e_nick = 1;
            m_credit -= 5;
            nick_left--;
        end
        e_disp = (vend_left > 0);
        e_busy = e_disp || e_nick;
    endtask

    task automatic compare_all();
        chk("dispense", 32'(dispense), 32'(e_disp));
        chk("nickel_out", 32'(nickel_out), 32'(e_nick));
        chk("coin_reject", 32'(coin_reject), 32'(e_rej));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("credit", 32'(credit), 32'(m_credit));
`ifdef SALES_COUNT_EN
        chk("sales_count", 32'(sales_count), 32'(m_sales));
`endif
    endtask

    // Called at a falling edge: drive, let the rising edge happen, check.
    task automatic cycle(input bit v, input logic [1:0] t, input bit c);
        coin_valid = v; coin_type = t; cancel = c;
        @(posedge clk);
        model_step(v, t, c);
        @(negedge clk);
        compare_all();
        disp_seen += int'(dispense);
        nick_seen += int'(nickel_out);
        coin_valid = 0; cancel = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, NK, 0);
    endtask

    task automatic c2cyc(input bit v, input logic [1:0] t);
        cv2 = v; ct2 = t;
        @(posedge clk);
        @(negedge clk);
        cv2 = 0;
    endtask

    initial begin
        reset = 0; coin_valid = 0; coin_type = NK; cancel = 0;
        cv2 = 0; ct2 = NK; cn2 = 0;
        model_reset();
        disp_seen = 0; nick_seen = 0;
        repeat (2) @(negedge clk);
        chk("reset credit", 32'(credit), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset dispense", 32'(dispense), 0);
        reset = 1;
        @(negedge clk);

        // Three quarters: vend exactly at price, nothing returned.
        cycle(1, QT, 0); chk("t1 credit 25", 32'(credit), 25);
        cycle(1, QT, 0); chk("t1 credit 50", 32'(credit), 50);
        disp_seen = 0; nick_seen = 0;
        cycle(1, QT, 0); chk("t1 vend credit", 32'(credit), 0);
        chk("t1 dispense on", 32'(dispense), 1);
        idle(8);
        chk("t1 dispense cycles", 32'(disp_seen), 4);
        chk("t1 nickels", 32'(nick_seen), 0);
        chk("t1 idle busy", 32'(busy), 0);

        // Eight dimes: 80 cents, one nickel change.
        for (int i = 0; i < 7; i++) cycle(1, DM, 0);
        chk("t2 credit 70", 32'(credit), 70);
        disp_seen = 0; nick_seen = 0;
        cycle(1, DM, 0); chk("t2 vend credit", 32'(credit), 5);
        idle(8);
        chk("t2 nickels", 32'(nick_seen), 1);
        chk("t2 final credit", 32'(credit), 0);

        // Quarter, dime, cancel: seven nickels, no dispense.
        cycle(1, QT, 0); cycle(1, DM, 0);
        chk("t3 credit 35", 32'(credit), 35);
        disp_seen = 0; nick_seen = 0;
        cycle(0, NK, 1); chk("t3 first pulse credit", 32'(credit), 30);
        idle(9);
        chk("t3 nickels", 32'(nick_seen), 7);
        chk("t3 dispense", 32'(disp_seen), 0);

        // Invalid coin is rejected and credit kept.
        cycle(1, QT, 0);
        cycle(1, BAD, 0);
        chk("t4 reject", 32'(coin_reject), 1);
        chk("t4 credit kept", 32'(credit), 25);
        cycle(0, NK, 1); idle(8);

        // Coin during VEND rejected; coin+cancel credits then refunds.
        cycle(1, QT, 0); cycle(1, QT, 0); cycle(1, QT, 0);
        cycle(1, QT, 0);
        chk("t5 vend reject", 32'(coin_reject), 1);
        chk("t5 vend credit", 32'(credit), 0);
        idle(6);
        cycle(1, QT, 0); cycle(1, QT, 0);
        disp_seen = 0; nick_seen = 0;
        cycle(1, DM, 1);
        chk("t5 coin+cancel credit", 32'(credit), 55);
        chk("t5 first nickel", 32'(nickel_out), 1);
        idle(14);
        chk("t5 nickels", 32'(nick_seen), 12);
        chk("t5 dispense", 32'(disp_seen), 0);
`ifdef SALES_COUNT_EN
        chk("sales after three vends", 32'(sales_count), 3);
`endif

        // Reset mid-refund: everything clears at once, no more nickels.
        cycle(1, QT, 0); cycle(1, DM, 0);
        cycle(0, NK, 1); chk("t6 refund credit", 32'(credit), 30);
        #2 reset = 0;
        #1;
        chk("t6 async credit", 32'(credit), 0);
        chk("t6 async nickel", 32'(nickel_out), 0);
        chk("t6 async busy", 32'(busy), 0);
        chk("t6 async dispense", 32'(dispense), 0);
        model_reset();
        @(negedge clk);
        reset = 1;
        nick_seen = 0;
        idle(3);
        chk("t6 no nickels after reset", 32'(nick_seen), 0);
        cycle(1, QT, 0); chk("t6 idle after reset", 32'(credit), 25);
        cycle(0, NK, 1); idle(8);

        // High-price instance: ceiling rejection near MAX_CREDIT.
        for (int i = 0; i < 7; i++) c2cyc(1, QT);
        c2cyc(1, DM); c2cyc(1, NK);
        chk("t4b credit 190", 32'(c2), 190);
        c2cyc(1, QT);
        chk("t4b ceiling reject", 32'(r2), 1);
        chk("t4b credit kept", 32'(c2), 190);
        c2cyc(1, NK); c2cyc(1, DM);
        chk("t4b reject 205", 32'(r2), 1);
        chk("t4b credit 195", 32'(c2), 195);
        c2cyc(1, NK);
        chk("t4b vend at 200", 32'(d2), 1);
        chk("t4b vend credit", 32'(c2), 0);

        // Random coin traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
